// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: access-size encoding,
// controller states and the default data RAM depth.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int LSU_MEM_BYTES = 4096;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_RD,
        WRITE,
        RESP,
        ERR
    } lsu_state_e;

endpackage

// File: rtl/lsu_lane_swap.sv
// Byte-lane conversion between core little-endian data and RAM packing,
// where the byte at the access address sits in bits [31:24] of the RAM word.
module lsu_lane_swap
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] r_data,
    input  logic [31:0] wdata,
    input  logic [31:0] old_data,
    output logic [31:0] ld_data,
    output logic [31:0] st_data
);

    // Right-justify the addressed bytes and extend them to a full word.
    function automatic logic [31:0] load_extract(input logic [1:0] sz,
                                                 input logic u,
                                                 input logic [31:0] r);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic [31:0]        res;
        b = r[31:24];
        h = {r[23:16], r[31:24]};
        case (sz)
            SZ_B:    res = u ? {24'd0, b} : 32'(b);
            SZ_H:    res = u ? {16'd0, h} : 32'(h);
            default: res = {r[7:0], r[15:8], r[23:16], r[31:24]};
        endcase
        return res;
    endfunction

    // Place store bytes in RAM order; untouched lanes keep the old RAM word.
    function automatic logic [31:0] store_merge(input logic [1:0] sz,
                                                input logic [31:0] d,
                                                input logic [31:0] o);
        logic [31:0] res;
        case (sz)
            SZ_B:    res = {d[7:0], o[23:0]};
            SZ_H:    res = {d[7:0], d[15:8], o[15:0]};
            default: res = {d[7:0], d[15:8], d[23:16], d[31:24]};
        endcase
        return res;
    endfunction

    // Pure lane steering; no state here.
    always_comb begin
        ld_data = load_extract(size, uns, r_data);
        st_data = store_merge(size, wdata, old_data);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller in front of the byte-addressed data RAM. Serves one
// request at a time; sub-word stores read the RAM word first so that the
// neighbouring bytes are written back unchanged.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_BYTES  = LSU_MEM_BYTES
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_we
);

    lsu_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [1:0]            size_q;
    logic                  we_q;
    logic                  uns_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] old_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] w_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  accept;
    logic                  req_bad;

    assign accept  = (state == IDLE) && req_valid;
    // The RAM always returns four bytes, so the last legal address is MEM_BYTES-4.
    assign req_bad = (req_size == 2'd3) || (req_addr > ADDR_WIDTH'(MEM_BYTES - 4));

    lsu_lane_swap u_lane_swap (
        .size     (size_q),
        .uns      (uns_q),
        .r_data   (ram_r_data),
        .wdata    (wdata_q),
        .old_data (old_q),
        .ld_data  (ld_data),
        .st_data  (st_data)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Request capture, load result, RMW old word and held RAM write port values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= '0;
            size_q   <= '0;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                size_q  <= req_size;
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata;
            end
            if (state == LOAD)   rdata_q <= ld_data;
            if (state == RMW_RD) old_q   <= ram_r_data;
            if (state == WRITE) begin
                w_addr_q <= addr_q;
                w_data_q <= st_data;
            end
        end
    end

    // Next-state and state-decoded handshake / RAM strobes.
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        ram_we     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)             state_nxt = ERR;
                    else if (!req_we)        state_nxt = LOAD;
                    else if (req_size == SZ_W) state_nxt = WRITE;
                    else                     state_nxt = RMW_RD;
                end
            end
            LOAD:   state_nxt = RESP;
            RMW_RD: state_nxt = WRITE;
            WRITE: begin
                ram_we    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The write port shows live values only while writing, and holds them otherwise.
    assign ram_r_addr = addr_q;
    assign ram_w_addr = ram_we ? addr_q  : w_addr_q;
    assign ram_w_data = ram_we ? st_data : w_data_q;
    assign resp_rdata = (state == RESP && !we_q) ? rdata_q : '0;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: a byte-array RAM beside the DUT, and a reference memory
// updated from the little-endian load/store rules to predict every response.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] ram_r_addr;
    logic [31:0] ram_r_data;
    logic [31:0] ram_w_addr;
    logic [31:0] ram_w_data;
    logic        ram_we;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram     [0:4095] = '{default: 8'h00};
    logic [7:0] ref_mem [0:4095] = '{default: 8'h00};

    always #5 clk = ~clk;

    lsu_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_r_addr   (ram_r_addr),
        .ram_r_data   (ram_r_data),
        .ram_w_addr   (ram_w_addr),
        .ram_w_data   (ram_w_data),
        .ram_we       (ram_we)
    );

    // RAM: combinational 4-byte read, clocked 4-byte write; byte at A in [31:24].
    always_comb begin
        ram_r_data = 32'd0;
        if (ram_r_addr <= 32'd4092)
            ram_r_data = {ram[ram_r_addr[11:0]],         ram[ram_r_addr[11:0] + 12'd1],
                          ram[ram_r_addr[11:0] + 12'd2], ram[ram_r_addr[11:0] + 12'd3]};
    end

    always @(posedge clk) begin
        if (ram_we && ram_w_addr <= 32'd4092) begin
            ram[ram_w_addr[11:0]]         <= ram_w_data[31:24];
            ram[ram_w_addr[11:0] + 12'd1] <= ram_w_data[23:16];
            ram[ram_w_addr[11:0] + 12'd2] <= ram_w_data[15:8];
            ram[ram_w_addr[11:0] + 12'd3] <= ram_w_data[7:0];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference load: gather 1/2/4 bytes little-endian, then extend.
    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                             input logic u);
        int          n;
        logic [63:0] v;
        n = 1 << sz;
        v = 64'd0;
        for (int i = 0; i < n; i++)
            v = v | (64'(ref_mem[a[11:0] + 12'(i)]) << (8 * i));
        if (!u && n < 4 && v[8 * n - 1])
            v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++)
            ref_mem[a[11:0] + 12'(i)] = d[8 * i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[11:0]], ref_mem[a[11:0] + 12'd1],
                ref_mem[a[11:0] + 12'd2], ref_mem[a[11:0] + 12'd3]};
    endfunction

    // One request: predict it, issue it, watch 6 cycles after acceptance.
    task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                          input logic u, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdata_o, output logic [31:0] wdata_o);
        logic        exp_err;
        int          exp_we_lat, exp_rv_lat;
        logic [31:0] exp_rdata, exp_wdata;
        int          we_first, we_cnt, rv_first, rv_cnt, wait_n;
        logic [31:0] got_rdata, got_waddr, got_wdata;
        logic        got_err;
        exp_err    = (sz == 2'd3) || (a > 32'd4092);
        exp_we_lat = (exp_err || !we) ? 0 : ((sz == SZ_W) ? 1 : 2);
        exp_rv_lat = exp_err ? 1 : ((!we || sz == SZ_W) ? 2 : 3);
        exp_rdata  = (exp_err || we) ? 32'd0 : ref_load(a, sz, u);
        exp_wdata  = 32'd0;
        if (!exp_err && we) begin
            ref_store(a, sz, d);
            exp_wdata = ref_word(a);
        end
        we_first = 0; we_cnt = 0; rv_first = 0; rv_cnt = 0; wait_n = 0;
        got_rdata = 32'd0; got_waddr = 32'd0; got_wdata = 32'd0; got_err = 1'b0;

        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = d;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (ram_we) begin
                we_cnt++;
                if (we_first == 0) begin
                    we_first  = k;
                    got_waddr = ram_w_addr;
                    got_wdata = ram_w_data;
                end
            end
            if (resp_valid) begin
                rv_cnt++;
                if (rv_first == 0) begin
                    rv_first  = k;
                    got_rdata = resp_rdata;
                    got_err   = resp_err;
                end
            end
        end
        check({tag, "_resp_lat"}, 32'(rv_first), 32'(exp_rv_lat));
        check({tag, "_resp_cnt"}, 32'(rv_cnt), 32'd1);
        check({tag, "_err"}, 32'(got_err), 32'(exp_err));
        check({tag, "_rdata"}, got_rdata, exp_rdata);
        check({tag, "_we_lat"}, 32'(we_first), 32'(exp_we_lat));
        check({tag, "_we_cnt"}, 32'(we_cnt), (exp_we_lat != 0) ? 32'd1 : 32'd0);
        if (exp_we_lat != 0) begin
            check({tag, "_waddr"}, got_waddr, a);
            check({tag, "_wdata"}, got_wdata, exp_wdata);
        end
        rdata_o = got_rdata;
        wdata_o = got_wdata;
    endtask

    initial begin
        logic [31:0] rd, wd;
        logic [5:0]  rvec, yvec;
        int          cnt_rv, cnt_we, diff;
        logic [1:0]  sz;
        logic [31:0] a;

        // Reset values, observed while reset is held.
        #1;
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_r_addr", ram_r_addr, 32'd0);
        check("rst_w_addr", ram_w_addr, 32'd0);
        check("rst_w_data", ram_w_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Word store then load back.
        do_req("sw10", 1'b1, SZ_W, 1'b0, 32'h10, 32'h11223344, rd, wd);
        check("sw10_wdata_const", wd, 32'h44332211);
        do_req("lw10", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, wd);
        check("lw10_const", rd, 32'h11223344);

        // Byte store into the middle of an existing word.
        do_req("sb11", 1'b1, SZ_B, 1'b0, 32'h11, 32'hFFFFFFAB, rd, wd);
        do_req("lw10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, rd, wd);
        check("lw10b_const", rd, 32'h1122AB44);

        // Sign/zero extension; upper store data bits are ignored.
        do_req("sh20", 1'b1, SZ_H, 1'b0, 32'h20, 32'h1234FF80, rd, wd);
        do_req("lb20", 1'b0, SZ_B, 1'b0, 32'h20, 32'h0, rd, wd);
        check("lb20_const", rd, 32'hFFFFFF80);
        do_req("lbu20", 1'b0, SZ_B, 1'b1, 32'h20, 32'h0, rd, wd);
        check("lbu20_const", rd, 32'h00000080);
        do_req("lh20", 1'b0, SZ_H, 1'b0, 32'h20, 32'h0, rd, wd);
        check("lh20_const", rd, 32'hFFFFFF80);

        // Address range and illegal size.
        do_req("sw_ffd", 1'b1, SZ_W, 1'b0, 32'hFFD, 32'hDEADBEEF, rd, wd);
        do_req("ld_sz3", 1'b0, 2'd3, 1'b0, 32'h30, 32'h0, rd, wd);
        do_req("sb_sz3", 1'b1, 2'd3, 1'b0, 32'h30, 32'hCAFEF00D, rd, wd);
        do_req("sw_ffc", 1'b1, SZ_W, 1'b0, 32'hFFC, 32'hA5A55A5A, rd, wd);
        do_req("lw_ffc", 1'b0, SZ_W, 1'b0, 32'hFFC, 32'h0, rd, wd);

        // Back-to-back loads with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h0;
        check("b2b_ready0", 32'(req_ready), 32'd1);
        rvec = '0; yvec = '0;
        @(posedge clk);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            rvec[k - 1] = resp_valid;
            yvec[k - 1] = req_ready;
            if (resp_valid) check("b2b_rdata", resp_rdata, ref_load(32'h10, SZ_W, 1'b0));
            if (k == 6) req_valid = 1'b0;
        end
        check("b2b_resp_vec", 32'(rvec), 32'(6'b010010));
        check("b2b_ready_vec", 32'(yvec), 32'(6'b100100));

        // Reset asserted while a byte store is in its write cycle.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = SZ_B; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'h0000005A;
        check("rstw_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("rstw_rmw_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        check("rstw_pre_we", 32'(ram_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rstw_we_drop", 32'(ram_we), 32'd0);
        check("rstw_resp", 32'(resp_valid), 32'd0);
        check("rstw_ready_in_rst", 32'(req_ready), 32'd1);
        check("rstw_w_addr", ram_w_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt_rv = 0; cnt_we = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid) cnt_rv++;
            if (ram_we) cnt_we++;
        end
        check("rstw_no_resp", 32'(cnt_rv), 32'd0);
        check("rstw_no_we", 32'(cnt_we), 32'd0);
        check("rstw_ready_after", 32'(req_ready), 32'd1);
        do_req("lb40", 1'b0, SZ_B, 1'b1, 32'h40, 32'h0, rd, wd);
        check("lb40_untouched", rd, 32'h0);

        // Randomized traffic over a small window plus the top-of-memory edge.
        for (int n = 0; n < 60; n++) begin
            sz = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(4088, 4100))
                                              : 32'($urandom_range(0, 63));
            do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, rd, wd);
        end

        // Whole RAM must match the reference memory.
        diff = 0;
        for (int i = 0; i < 4096; i++)
            if (ram[i] !== ref_mem[i]) diff++;
        check("ram_vs_model", 32'(diff), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
